// File: rtl/w0rm_irq_controller_pkg.sv
// ---------------------------------------------------------------------------
// w0rm_irq_controller_pkg
// Shared definitions for the W0RM peripheral interrupt controller:
//   - register byte offsets within the 16-byte register block
//   - reserved vector number for the core interrupt
//   - register-select enum and an offset decode helper
// No ports (package).
// ---------------------------------------------------------------------------
package w0rm_irq_controller_pkg;

  localparam logic [3:0] IRQ_REG_ENABLE  = 4'h0;
  localparam logic [3:0] IRQ_REG_EDGE    = 4'h4;
  localparam logic [3:0] IRQ_REG_PENDING = 4'h8;
  localparam logic [3:0] IRQ_REG_ACTIVE  = 4'hC;

  // Vector 0 belongs to the core interrupt; peripheral lines start at 1.
  localparam int IRQ_VECTOR_CORE = 0;

  typedef enum logic [1:0] {
    REG_ENABLE  = 2'd0,
    REG_EDGE    = 2'd1,
    REG_PENDING = 2'd2,
    REG_ACTIVE  = 2'd3
  } irq_reg_e;

  typedef struct packed {
    logic     hit;
    irq_reg_e sel;
  } irq_decode_t;

  // Only the four word-aligned offsets are mapped; anything else misses.
  function automatic irq_decode_t decode_offset(input logic [3:0] off);
    irq_decode_t d;
    d.hit = 1'b1;
    d.sel = REG_ENABLE;
    case (off)
      IRQ_REG_ENABLE:  d.sel = REG_ENABLE;
      IRQ_REG_EDGE:    d.sel = REG_EDGE;
      IRQ_REG_PENDING: d.sel = REG_PENDING;
      IRQ_REG_ACTIVE:  d.sel = REG_ACTIVE;
      default:         d.hit = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/w0rm_irq_priority_encoder.sv
// ---------------------------------------------------------------------------
// w0rm_irq_priority_encoder
// Combinational lowest-index-wins priority encoder.
// Ports:
//   req    in  NUM_IRQ   - request vector (already masked)
//   any    out 1         - at least one request bit set
//   number out ISR_WIDTH - winning index + 1, or the core vector when idle
// ---------------------------------------------------------------------------
module w0rm_irq_priority_encoder
  import w0rm_irq_controller_pkg::*;
#(
  parameter int NUM_IRQ   = 16,
  parameter int ISR_WIDTH = 8
) (
  input  logic [NUM_IRQ-1:0]   req,
  output logic                 any,
  output logic [ISR_WIDTH-1:0] number
);

  // Scan from the top down so the lowest set index is the last assignment.
  always_comb begin
    any    = 1'b0;
    number = ISR_WIDTH'(IRQ_VECTOR_CORE);
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        any    = 1'b1;
        number = ISR_WIDTH'(i + 1);
      end
    end
  end

endmodule

// File: rtl/w0rm_irq_controller.sv
// ---------------------------------------------------------------------------
// w0rm_irq_controller
// Peripheral interrupt aggregator for the W0RM core. Latches request lines
// (edge or level per line), masks with ENABLE, and presents the lowest
// pending enabled line as vector index + 1.
// Ports:
//   clk, reset                 - clock, async active-high reset
//   irq[NUM_IRQ]               - peripheral request lines
//   isr_ack                    - core took the presented vector
//   peripheral_interrupt       - pending enabled line exists
//   peripheral_isr_number      - presented vector (line + 1)
//   mem_valid/read/write/addr/data_in - register bus request
//   mem_valid_out/mem_data_out - read response, one cycle after request
// ---------------------------------------------------------------------------
module w0rm_irq_controller
  import w0rm_irq_controller_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    ISR_WIDTH  = 8,
  parameter int                    NUM_IRQ    = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h8000_0100)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_IRQ-1:0]    irq,
  input  logic                  isr_ack,
  output logic                  peripheral_interrupt,
  output logic [ISR_WIDTH-1:0]  peripheral_isr_number,
  input  logic                  mem_valid,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_valid_out,
  output logic [DATA_WIDTH-1:0] mem_data_out
);

  logic [NUM_IRQ-1:0]   irq_r, irq_p;
  logic [NUM_IRQ-1:0]   pending, enable_q, edge_q;
  logic [NUM_IRQ-1:0]   rose, ack_line, w1c_line, pending_next;
  logic                 sel_any;
  logic [ISR_WIDTH-1:0] sel_num;
  irq_decode_t          dec;
  logic                 block_hit, wr_en, rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                 unused_data;

  // Data bits above NUM_IRQ are ignored on write.
  assign unused_data = ^mem_data_in;

  assign block_hit = (mem_addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
  assign dec       = decode_offset(mem_addr[3:0]);
  // read+write together is a write
  assign wr_en     = mem_valid & mem_write & block_hit & dec.hit;
  assign rd_en     = mem_valid & mem_read & ~mem_write & block_hit & dec.hit;

  assign rose     = irq_r & ~irq_p;
  assign w1c_line = (wr_en && dec.sel == REG_PENDING) ? mem_data_in[NUM_IRQ-1:0] : '0;

  // An ack only clears the line currently being presented to the core.
  always_comb begin
    ack_line = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ack_line[i] = isr_ack & peripheral_interrupt &
                    (peripheral_isr_number == ISR_WIDTH'(i + 1));
    end
  end

  // Edge lines: a new edge beats a simultaneous clear. Level lines follow irq_r.
  assign pending_next = (edge_q & (rose | (pending & ~(ack_line | w1c_line)))) |
                        (~edge_q & irq_r);

  always_comb begin
    rd_data = '0;
    case (dec.sel)
      REG_ENABLE:  rd_data = DATA_WIDTH'(enable_q);
      REG_EDGE:    rd_data = DATA_WIDTH'(edge_q);
      REG_PENDING: rd_data = DATA_WIDTH'(pending);
      REG_ACTIVE:  rd_data = DATA_WIDTH'({peripheral_interrupt, peripheral_isr_number});
      default:     rd_data = '0;
    endcase
  end

  w0rm_irq_priority_encoder #(
    .NUM_IRQ   (NUM_IRQ),
    .ISR_WIDTH (ISR_WIDTH)
  ) u_prio (
    .req    (pending & enable_q),
    .any    (sel_any),
    .number (sel_num)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_r    <= '0;
      irq_p    <= '0;
      pending  <= '0;
      enable_q <= '0;
      edge_q   <= '0;
    end else begin
      irq_r   <= irq;
      irq_p   <= irq_r;
      pending <= pending_next;
      if (wr_en && dec.sel == REG_ENABLE) enable_q <= mem_data_in[NUM_IRQ-1:0];
      if (wr_en && dec.sel == REG_EDGE)   edge_q   <= mem_data_in[NUM_IRQ-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peripheral_interrupt  <= 1'b0;
      peripheral_isr_number <= '0;
      mem_valid_out         <= 1'b0;
      mem_data_out          <= '0;
    end else begin
      peripheral_interrupt  <= sel_any;
      peripheral_isr_number <= sel_num;
      mem_valid_out         <= rd_en;
      if (rd_en) mem_data_out <= rd_data;
    end
  end

endmodule
